// File: rtl/uart_rx_if.sv
// uart_rx_if: receive-side handshake bundle of the UART receiver.
//   rx_data       received byte, stable while rx_valid is high
//   rx_valid      holding register full
//   rx_ready      consumer accepts rx_data when rx_valid & rx_ready
//   framing_error one-cycle pulse, stop bit sampled low
//   parity_error  one-cycle pulse, parity mismatch
//   overrun       one-cycle pulse, frame completed while holding register full
// master: the receiver (drives data/valid/errors); slave: the consumer.
interface uart_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       framing_error;
  logic       parity_error;
  logic       overrun;

  modport master (
    output rx_data, rx_valid, framing_error, parity_error, overrun,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, framing_error, parity_error, overrun,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver, 8 data bits LSB first, optional
// parity, one stop bit. Each byte is presented through a valid/ready
// holding register; framing, parity and overrun errors are one-cycle pulses.
//   clk    system clock, rising edge
//   rst    asynchronous reset, active low
//   rx     asynchronous serial line, idle high
//   rx_if  handshake bundle (master side)
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | line idle, waiting for a falling edge
// S_START | counting half a bit to re-check the start bit at mid-bit
// S_DATA  | sampling 8 data bits at mid-bit, LSB first
// S_PARITY| sampling the parity bit (only when PARITY != 0)
// S_STOP  | sampling the stop bit, delivering or reporting the frame
// S_BREAK | stop bit was low; waiting for the line to return high
module uart_rx #(
  parameter int CLOCK_FREQ = 100000000,
  parameter int BAUD_RATE  = 9600,
  parameter int BAUD_DIV   = CLOCK_FREQ / BAUD_RATE,
  parameter int PARITY     = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  uart_rx_if.master rx_if
);

  localparam logic [15:0] DIV_M1  = 16'(BAUD_DIV - 1);
  localparam logic [15:0] HALF_M1 = 16'(BAUD_DIV / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_e;

  state_e      state_q, state_d;
  logic        rx_meta_q, rx_meta_d;
  logic        rx_s_q, rx_s_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        perr_q, perr_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        fe_q, fe_d;
  logic        pe_q, pe_d;
  logic        ov_q, ov_d;

  logic        tick;
  logic        par_exp;

  assign tick    = (cnt_q == 16'd0);
  // Odd parity: data plus parity bit has an odd number of ones.
  assign par_exp = (PARITY == 1) ? ~(^shift_q) : (^shift_q);

  always_comb begin
    rx_meta_d = rx;
    rx_s_d    = rx_meta_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    perr_d    = perr_q;
    data_d    = data_q;
    valid_d   = valid_q;
    fe_d      = 1'b0;
    pe_d      = 1'b0;
    ov_d      = 1'b0;

    if (valid_q && rx_if.rx_ready) begin
      valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          cnt_d   = HALF_M1;
          state_d = S_START;
        end
      end

      S_START: begin
        if (tick) begin
          if (!rx_s_q) begin
            cnt_d     = DIV_M1;
            bit_idx_d = 3'd0;
            perr_d    = 1'b0;
            state_d   = S_DATA;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end

      S_DATA: begin
        if (tick) begin
          cnt_d            = DIV_M1;
          shift_d[bit_idx_q] = rx_s_q;
          if (bit_idx_q == 3'd7) begin
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end

      S_PARITY: begin
        if (tick) begin
          cnt_d = DIV_M1;
          if (rx_s_q != par_exp) begin
            perr_d = 1'b1;
          end
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end

      S_STOP: begin
        if (tick) begin
          // Leave at mid-stop so the next start edge is never missed.
          state_d = S_IDLE;
          if (!rx_s_q) begin
            fe_d    = 1'b1;
            state_d = S_BREAK;
          end else if (perr_q) begin
            pe_d = 1'b1;
          end else if (!valid_q || rx_if.rx_ready) begin
            // Covers the simultaneous accept-and-load case too.
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            ov_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end

      S_BREAK: begin
        if (rx_s_q) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      cnt_q     <= 16'd0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'd0;
      perr_q    <= 1'b0;
      data_q    <= 8'd0;
      valid_q   <= 1'b0;
      fe_q      <= 1'b0;
      pe_q      <= 1'b0;
      ov_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      rx_meta_q <= rx_meta_d;
      rx_s_q    <= rx_s_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      perr_q    <= perr_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      fe_q      <= fe_d;
      pe_q      <= pe_d;
      ov_q      <= ov_d;
    end
  end

  assign rx_if.rx_data       = data_q;
  assign rx_if.rx_valid      = valid_q;
  assign rx_if.framing_error = fe_q;
  assign rx_if.parity_error  = pe_q;
  assign rx_if.overrun       = ov_q;

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Standalone UART receiver: the serial-in end of the team's UART link, paired with the transmit path of the uart block. Oversamples the line with a baud-divider counter, recovers 8N1 (optional parity) frames LSB-first, and presents each byte through a valid/ready holding register. Reports framing, parity and overrun errors.

Parameters:
CLOCK_FREQ, 100000000, system clock frequency in Hz
BAUD_RATE, 9600, line bit rate in bits/s
BAUD_DIV, CLOCK_FREQ/BAUD_RATE, clock cycles per bit; must be in 4..65535
PARITY, 0, 0 = none, 1 = odd, 2 = even

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  reset, asynchronous assert, active-low (0 = reset)
rx  input  1  asynchronous serial line, idle high
rx_data  output  8  received byte, stable while rx_valid=1
rx_valid  output  1  holding register full
rx_ready  input  1  consumer accepts rx_data when rx_valid & rx_ready
framing_error  output  1  one-cycle pulse: stop bit sampled 0
parity_error  output  1  one-cycle pulse: parity mismatch
overrun  output  1  one-cycle pulse: frame completed while holding register full

Behaviour:
- Clocking/reset: one clock; reset is asynchronous and active-low. During reset: rx_data=0, rx_valid=0, all error pulses=0, state=IDLE, synchroniser flops=1.
- Input sync: rx passes through 2 flops (rx_s). All decisions use rx_s; 2-cycle latency from pin.
- Bit counter: 16-bit down-counter; a "tick" occurs when it reaches 0, after which it reloads BAUD_DIV-1 (bit period = BAUD_DIV cycles).
- IDLE: on rx_s=0 load counter with BAUD_DIV/2-1, go START.
- START: on tick, if rx_s=0 (valid start at mid-bit), reload, bit index=0, go DATA; if rx_s=1, false start, go IDLE, nothing reported.
- DATA: on each tick sample rx_s into shift reg bit [index] (LSB first); after bit 7, go PARITY if PARITY!=0, else STOP.
- PARITY: on tick, compare rx_s with expected (odd: XOR(data)^1; even: XOR(data)); mismatch sets internal perr flag; go STOP.
- STOP: on tick sample rx_s.
  - rx_s=1, perr=0: deliver byte (see handshake); go IDLE immediately (mid-stop bit), ready for next falling edge.
  - rx_s=1, perr=1: parity_error pulse, byte discarded, go IDLE.
  - rx_s=0: framing_error pulse (parity_error suppressed), byte discarded, go BREAK.
- BREAK: wait until rx_s=1, then go IDLE (line held low never produces repeated frames).
- Handshake / delivery in the cycle STOP completes:
  - rx_valid=0: rx_data<=byte, rx_valid<=1 next cycle.
  - rx_valid=1 & rx_ready=1 same cycle: old byte consumed, new byte loaded, rx_valid stays 1, no overrun.
  - rx_valid=1 & rx_ready=0: overrun pulse, new byte dropped, rx_data unchanged.
- rx_valid clears the cycle after rx_valid & rx_ready with no new delivery. rx_data unchanged while rx_valid=1 except on the simultaneous accept/load case.
- Error pulses are exactly one clock high; at most one error pulse per frame.
- Latency: rx_valid rises 2 (sync) + 1 cycles after the mid-stop-bit tick.
- Reset mid-frame: all state abandoned, no partial byte or error output afterwards; reception restarts on the next falling edge after release.

Test Plan:
Bench uses CLOCK_FREQ=160, BAUD_RATE=10 (BAUD_DIV=16).
1. PARITY=0, send 0xA5 8N1, rx_ready=1 -> rx_valid one cycle with rx_data=0xA5; no error pulses; valid ~2+1 cycles after stop mid-point.
2. Back-to-back 0x00, 0xFF, 0x55 with rx_ready=0 until all three sent -> rx_data=0x00 held, two overrun pulses; then ready=1 -> 0x00 consumed, rx_valid=0.
3. rx low for 5 cycles then high (glitch) -> no rx_valid, no errors, state returns IDLE; following 0x3C received correctly.
4. Send 0x81 with stop bit 0, then line held low 100 cycles -> one framing_error pulse, no rx_valid, no further frames until line high; then 0x7E received.
5. PARITY=2, send 0x07 with parity bit 0 (wrong) -> one parity_error pulse, no rx_valid; with parity bit 1 -> rx_data=0x07, no error.
6. Assert rst=0 during DATA bit 4 of 0xC3 -> outputs 0 immediately; release, send 0x12 -> rx_data=0x12 only.
